// File: rtl/pll_supervisor.sv
// PLL lock supervisor: drives the PLL reset, qualifies lock, then releases
// the downstream domain resets one at a time in ascending order.
module pll_supervisor #(
    parameter int NUM_OUTPUTS    = 3,
    parameter int PLL_RST_CYCLES = 8,
    parameter int LOCK_TIMEOUT   = 1000,
    parameter int SETTLE_CYCLES  = 64,
    parameter int STAGGER_CYCLES = 4,
    parameter int MAX_RETRIES    = 4,
    parameter int CNT_W          = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   pll_locked_i,
    input  logic                   restart_i,
    output logic                   pll_rst_o,
    output logic [NUM_OUTPUTS-1:0] rst_out_o,
    output logic                   ready_o,
    output logic                   lock_lost_o,
    output logic                   fail_o,
    output logic [7:0]             retry_count_o,
    output logic [2:0]             state_o
);

    localparam int IDX_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

    localparam logic [CNT_W-1:0] P_RST_LAST =
        CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] P_TMO_LAST =
        CNT_W'(LOCK_TIMEOUT - 1);
    // The lock sample that moves WAIT_LOCK into SETTLE is the first
    // of the contiguous run, so SETTLE itself needs one sample fewer.
    localparam logic [CNT_W-1:0] P_SETTLE_LAST =
        CNT_W'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] P_STAG_LAST =
        CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] P_IDX_LAST =
        IDX_W'(NUM_OUTPUTS - 1);
    localparam logic [7:0] P_MAX_RETRY = 8'(MAX_RETRIES);
    localparam logic [NUM_OUTPUTS-1:0] P_FIRST_REL =
        ~NUM_OUTPUTS'(1);
    localparam bit P_SKIP_SETTLE = (SETTLE_CYCLES == 1);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_SETTLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    state_t                 r_state;
    logic                   r_lock_m;
    logic                   r_lock_s;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_pll_rst;
    logic [NUM_OUTPUTS-1:0] r_rst_out;
    logic                   r_ready;
    logic                   r_lock_lost;
    logic                   r_fail;
    logic [7:0]             r_retry;

    logic [7:0]             w_retry_nxt;
    logic [IDX_W-1:0]       w_next_idx;
    logic [NUM_OUTPUTS-1:0] w_clr_mask;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_lock_m <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_lock_m <= pll_locked_i;
            r_lock_s <= r_lock_m;
        end
    end

    always_comb begin
        w_retry_nxt = (r_retry == 8'hFF) ? 8'hFF : r_retry + 8'd1;
        w_next_idx  = r_idx + IDX_W'(1);
        w_clr_mask  = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            w_clr_mask[i] = (w_next_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_RESET_PLL;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_pll_rst   <= 1'b1;
            r_rst_out   <= '1;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
            r_fail      <= 1'b0;
            r_retry     <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (restart_i) begin
                r_state     <= S_RESET_PLL;
                r_cnt       <= '0;
                r_idx       <= '0;
                r_pll_rst   <= 1'b1;
                r_rst_out   <= '1;
                r_ready     <= 1'b0;
                r_lock_lost <= 1'b0;
                r_fail      <= 1'b0;
                r_retry     <= '0;
            end else begin
                unique case (r_state)
                    S_RESET_PLL: begin
                        if (r_cnt == P_RST_LAST) begin
                            r_state   <= S_WAIT_LOCK;
                            r_cnt     <= '0;
                            r_pll_rst <= 1'b0;
                        end
                    end
                    S_WAIT_LOCK: begin
                        if (r_lock_s) begin
                            r_cnt <= '0;
                            if (P_SKIP_SETTLE) begin
                                r_state   <= S_RELEASE;
                                r_idx     <= '0;
                                r_rst_out <= P_FIRST_REL;
                            end else begin
                                r_state <= S_SETTLE;
                            end
                        end else if (r_cnt == P_TMO_LAST) begin
                            r_cnt     <= '0;
                            r_retry   <= w_retry_nxt;
                            r_pll_rst <= 1'b1;
                            if (w_retry_nxt >= P_MAX_RETRY) begin
                                r_state <= S_FAIL;
                                r_fail  <= 1'b1;
                            end else begin
                                r_state <= S_RESET_PLL;
                            end
                        end
                    end
                    S_SETTLE: begin
                        if (!r_lock_s) begin
                            r_state <= S_WAIT_LOCK;
                            r_cnt   <= '0;
                        end else if (r_cnt == P_SETTLE_LAST) begin
                            r_state   <= S_RELEASE;
                            r_cnt     <= '0;
                            r_idx     <= '0;
                            r_rst_out <= P_FIRST_REL;
                        end
                    end
                    S_RELEASE: begin
                        if (!r_lock_s) begin
                            r_state     <= S_RESET_PLL;
                            r_cnt       <= '0;
                            r_pll_rst   <= 1'b1;
                            r_rst_out   <= '1;
                            r_ready     <= 1'b0;
                            r_lock_lost <= 1'b1;
                        end else if (r_cnt == P_STAG_LAST) begin
                            r_cnt <= '0;
                            if (r_idx == P_IDX_LAST) begin
                                r_state   <= S_RUN;
                                r_rst_out <= '0;
                                r_ready   <= 1'b1;
                            end else begin
                                r_idx     <= w_next_idx;
                                r_rst_out <= r_rst_out & ~w_clr_mask;
                            end
                        end
                    end
                    S_RUN: begin
                        if (!r_lock_s) begin
                            r_state     <= S_RESET_PLL;
                            r_cnt       <= '0;
                            r_pll_rst   <= 1'b1;
                            r_rst_out   <= '1;
                            r_ready     <= 1'b0;
                            r_lock_lost <= 1'b1;
                        end
                    end
                    S_FAIL: begin
                        r_cnt <= '0;
                    end
                    default: begin
                        r_state   <= S_RESET_PLL;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                        r_rst_out <= '1;
                        r_ready   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pll_rst_o     = r_pll_rst;
    assign rst_out_o     = r_rst_out;
    assign ready_o       = r_ready;
    assign lock_lost_o   = r_lock_lost;
    assign fail_o        = r_fail;
    assign retry_count_o = r_retry;
    assign state_o       = r_state;

endmodule

// File: doc/pll_supervisor.md
Name: pll_supervisor

Overview:
- Parametrised PLL lock supervisor and reset sequencer; successor to the fixed single-output PLL wrapper.
- Runs on the free-running reference clock and drives the PLL RST input.
- Waits for LOCKED with a timeout and bounded retries, then confirms lock stability.
- Releases NUM_OUTPUTS downstream domain resets in staggered order; on lock loss it re-asserts all of them and restarts the PLL.

Parameters:
NUM_OUTPUTS, 3, number of downstream reset outputs (1..16)
PLL_RST_CYCLES, 8, cycles pll_rst_o held high per PLL reset (>=1)
LOCK_TIMEOUT, 1000, max cycles in WAIT_LOCK before retry (>=1)
SETTLE_CYCLES, 64, contiguous synchronised-lock cycles required before release (>=1)
STAGGER_CYCLES, 4, cycles between successive reset releases (>=1)
MAX_RETRIES, 4, lock timeouts tolerated before FAIL (1..255)
CNT_W, 16, state counter width; every cycle parameter must be < 2^CNT_W

Ports:
clk_i  input  1  reference clock, free-running, independent of PLL
rst_n_i  input  1  asynchronous active-low reset
pll_locked_i  input  1  PLL LOCKED, asynchronous to clk_i
restart_i  input  1  single-cycle request to restart the whole sequence
pll_rst_o  output  1  PLL reset, active high
rst_out_o  output  NUM_OUTPUTS  per-domain resets, active high
ready_o  output  1  all domains released, lock stable
lock_lost_o  output  1  sticky: lock dropped after SETTLE passed; cleared by restart_i
fail_o  output  1  retries exhausted
retry_count_o  output  8  lock timeouts since last restart, saturates at 255
state_o  output  3  current state encoding, for debug

Behaviour:
- All outputs are registered. Reset values: pll_rst_o=1, rst_out_o=all ones, ready_o=0, lock_lost_o=0, fail_o=0, retry_count_o=0, state_o=RESET_PLL (0).
- Lock synchroniser:
  - pll_locked_i passes through 2 flops to give lock_s.
  - The state machine uses only lock_s, which lags pll_locked_i by 2 cycles.
  - Synchroniser flops reset to 0.
- State counter: cleared on every state entry, increments each cycle.
- States and encodings:
  - RESET_PLL (0): pll_rst_o=1, rst_out_o all ones.
    - After PLL_RST_CYCLES cycles -> WAIT_LOCK.
    - pll_rst_o is high for exactly PLL_RST_CYCLES cycles.
  - WAIT_LOCK (1): pll_rst_o=0.
    - lock_s=1 -> SETTLE.
    - Counter reaches LOCK_TIMEOUT-1 with lock_s=0 -> retry_count++ (saturating).
      - If the new count >= MAX_RETRIES -> FAIL.
      - Otherwise -> RESET_PLL.
  - SETTLE (2):
    - lock_s=0 -> WAIT_LOCK. Counter restarts; retry_count is unchanged.
    - SETTLE_CYCLES consecutive cycles of lock_s=1 -> RELEASE, idx=0.
  - RELEASE (3):
    - On entry, rst_out_o[0] clears.
    - Every STAGGER_CYCLES thereafter, the next index clears, in ascending order. Bits clear one per step and never re-assert in this state.
    - STAGGER_CYCLES after the last bit clears -> RUN.
    - With NUM_OUTPUTS=1, RUN is entered STAGGER_CYCLES after entry.
  - RUN (4): ready_o=1, rst_out_o all zero.
  - FAIL (5): pll_rst_o=1, rst_out_o all ones, fail_o=1. Held until restart_i.
- Lock loss:
  - lock_s=0 in RELEASE or RUN causes, in the same cycle (registered, visible next edge):
    - rst_out_o all ones, ready_o=0, lock_lost_o=1;
    - transition to RESET_PLL.
  - Lock loss does not increment retry_count.
- restart_i:
  - Honoured in every state and takes priority over all other transitions.
  - Next state is RESET_PLL; retry_count_o, lock_lost_o and fail_o clear, and rst_out_o goes all ones.
  - restart_i while already in RESET_PLL restarts the PLL_RST_CYCLES count.
- Simultaneous events:
  - restart_i beats lock loss and timeout.
  - A timeout coinciding with lock_s rising: lock wins (-> SETTLE).
- ready_o=1 implies rst_out_o all zero and pll_rst_o=0.
- Asynchronous rst_n_i assertion at any time forces all reset values immediately, including mid-RELEASE.

Test Plan:
- Defaults; release rst_n_i; raise pll_locked_i 20 cycles after pll_rst_o falls and hold it -> pll_rst_o high for exactly 8 cycles. lock_s rises 2 cycles after pll_locked_i. rst_out_o[0] clears 64 cycles after lock_s rises, [1] 4 cycles later, [2] 8 cycles later. ready_o=1 at +12.
- pll_locked_i held low -> 4 timeouts of 1000 cycles, each followed by an 8-cycle pll_rst_o pulse. retry_count_o steps 1,2,3,4. fail_o=1 and state_o=5 after the 4th timeout; state stays in FAIL.
- Lock glitch low for 3 cycles at SETTLE count 30 -> returns to WAIT_LOCK. On relock, rst_out_o[0] clears 64 cycles after the new lock_s rise; retry_count_o stays 0.
- Drop pll_locked_i in RUN -> 2 cycles later lock_s=0; next edge rst_out_o=3'b111, ready_o=0, lock_lost_o=1, pll_rst_o=1. lock_lost_o stays 1 after relock and ready.
- In FAIL, or mid-RELEASE after rst_out_o[0] has cleared, pulse restart_i -> rst_out_o=3'b111, fail_o=0, retry_count_o=0, lock_lost_o=0, state_o=0, and pll_rst_o high for 8 cycles.
- Assert rst_n_i low mid-RELEASE -> all outputs take reset values asynchronously. NUM_OUTPUTS=1, STAGGER_CYCLES=1 build reaches RUN 1 cycle after RELEASE entry.
